// File: rtl/fir_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fir_pkg                                                       |
// | Purpose  : Shared types and default widths for the FIR coefficient       |
// |            reader: FSM state encoding, sample/coef/accumulator defaults, |
// |            and the tap/ring address width.                               |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
package fir_pkg;

  localparam int FIR_SAMPLE_W = 24;   // signed audio sample width
  localparam int FIR_COEF_W   = 16;   // signed Q1.15 coefficient width
  localparam int FIR_ACC_W    = 48;   // signed accumulator width
  localparam int TAP_ADDR_W   = 8;    // tap index / ring address width
  localparam int RING_DEPTH   = 1 << TAP_ADDR_W;
  localparam int FRAC_BITS    = 15;   // Q1.15 fractional bits

  typedef enum logic [2:0] {
    ST_CLEAR = 3'd0,
    ST_IDLE  = 3'd1,
    ST_MAC   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_OUT   = 3'd4
  } fir_state_t;

endpackage : fir_pkg
`default_nettype wire

// File: rtl/fir_sample_ring.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fir_sample_ring                                               |
// | Purpose  : Sample history ring, RING_DEPTH x SAMPLE_W, synchronous write |
// |            and asynchronous (combinational) read.                        |
// | Ports    : clk       - clock                                             |
// |            i_wr_en   - write enable                                      |
// |            i_wr_addr - write address                                     |
// |            i_wr_data - write data                                        |
// |            i_rd_addr - read address                                      |
// |            o_rd_data - read data, same cycle as i_rd_addr                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fir_sample_ring
  import fir_pkg::*;
#(
  parameter int SAMPLE_W = FIR_SAMPLE_W
) (
  input  logic                  clk,
  input  logic                  i_wr_en,
  input  logic [TAP_ADDR_W-1:0] i_wr_addr,
  input  logic [SAMPLE_W-1:0]   i_wr_data,
  input  logic [TAP_ADDR_W-1:0] i_rd_addr,
  output logic [SAMPLE_W-1:0]   o_rd_data
);

  // Storage has no reset: the owner sweeps it to zero after every reset.
  logic [SAMPLE_W-1:0] r_mem [RING_DEPTH];

  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_mem[i_wr_addr] <= i_wr_data;
    end
  end

  assign o_rd_data = r_mem[i_rd_addr];

endmodule : fir_sample_ring
`default_nettype wire

// File: rtl/fir_coef_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : fir_coef_reader                                               |
// | Purpose  : Sequential single-MAC FIR. Each accepted sample is written    |
// |            into a 256-entry history ring, then taps 0..N are multiplied  |
// |            with coefficients fetched from an external combinational RAM, |
// |            accumulated, scaled by >>>15 and saturated to SAMPLE_W.       |
// | Ports    : clk, reset_n (async, active low)                              |
// |            sample_strobe/sample_in - new sample                          |
// |            taps_per_filter         - highest tap index N                 |
// |            coef_rd_addr/coefficients - coefficient RAM port              |
// |            filter_out/out_valid    - result and update pulse             |
// |            busy                    - high outside IDLE                   |
// |            overrun                 - pulse when a strobe is dropped      |
// | Config   : FIR_ROUND_EN - when defined, round half up before the shift;  |
// |            otherwise truncate.                                           |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module fir_coef_reader
  import fir_pkg::*;
#(
  parameter int SAMPLE_W = FIR_SAMPLE_W,
  parameter int COEF_W   = FIR_COEF_W,
  parameter int ACC_W    = FIR_ACC_W
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  sample_strobe,
  input  logic [SAMPLE_W-1:0]   sample_in,
  input  logic [TAP_ADDR_W-1:0] taps_per_filter,
  output logic [TAP_ADDR_W-1:0] coef_rd_addr,
  input  logic [COEF_W-1:0]     coefficients,
  output logic [SAMPLE_W-1:0]   filter_out,
  output logic                  out_valid,
  output logic                  busy,
  output logic                  overrun
);

  // Product width; the accumulator is assumed wider so sums have headroom.
  localparam int c_prod_w = SAMPLE_W + COEF_W;

`ifdef FIR_ROUND_EN
  localparam logic signed [ACC_W-1:0] c_round = ACC_W'(1 << (FRAC_BITS - 1));
`else
  localparam logic signed [ACC_W-1:0] c_round = '0;
`endif

  localparam logic signed [ACC_W-1:0] c_out_max =
    {{(ACC_W-SAMPLE_W+1){1'b0}}, {(SAMPLE_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] c_out_min =
    {{(ACC_W-SAMPLE_W+1){1'b1}}, {(SAMPLE_W-1){1'b0}}};

  fir_state_t r_state, w_state_nxt;

  logic [TAP_ADDR_W-1:0]      r_clr_idx;
  logic [TAP_ADDR_W-1:0]      r_wr_ptr;
  logic [TAP_ADDR_W-1:0]      r_tap;
  logic [TAP_ADDR_W-1:0]      r_taps_n;
  logic signed [c_prod_w-1:0] r_prod;
  logic signed [ACC_W-1:0]    r_acc;
  logic [SAMPLE_W-1:0]        r_filter_out;
  logic                       r_out_valid;
  logic                       r_overrun;

  logic                       w_ring_we;
  logic [TAP_ADDR_W-1:0]      w_ring_waddr;
  logic [SAMPLE_W-1:0]        w_ring_wdata;
  logic [TAP_ADDR_W-1:0]      w_ring_raddr;
  logic [SAMPLE_W-1:0]        w_ring_rdata;
  logic                       w_acc_en;
  logic signed [c_prod_w-1:0] w_samp_x;
  logic signed [c_prod_w-1:0] w_coef_x;
  logic signed [c_prod_w-1:0] w_prod;
  logic signed [ACC_W-1:0]    w_prod_ext;
  logic signed [ACC_W-1:0]    w_acc_rnd;
  logic signed [ACC_W-1:0]    w_acc_shift;
  logic [SAMPLE_W-1:0]        w_sat;

  // Newest sample lives at wr_ptr; tap k reaches k samples into the past.
  assign w_ring_raddr = r_wr_ptr - r_tap;

  fir_sample_ring #(
    .SAMPLE_W (SAMPLE_W)
  ) u_ring (
    .clk       (clk),
    .i_wr_en   (w_ring_we),
    .i_wr_addr (w_ring_waddr),
    .i_wr_data (w_ring_wdata),
    .i_rd_addr (w_ring_raddr),
    .o_rd_data (w_ring_rdata)
  );

  // Operands are sign-extended to the full product width first so the
  // truncated product is exact.
  assign w_samp_x   = {{COEF_W{w_ring_rdata[SAMPLE_W-1]}}, w_ring_rdata};
  assign w_coef_x   = {{SAMPLE_W{coefficients[COEF_W-1]}}, coefficients};
  assign w_prod     = w_samp_x * w_coef_x;
  assign w_prod_ext = {{(ACC_W-c_prod_w){r_prod[c_prod_w-1]}}, r_prod};

  assign w_acc_rnd   = r_acc + c_round;
  assign w_acc_shift = w_acc_rnd >>> FRAC_BITS;

  always_comb begin
    if (w_acc_shift > c_out_max) begin
      w_sat = {1'b0, {(SAMPLE_W-1){1'b1}}};
    end else if (w_acc_shift < c_out_min) begin
      w_sat = {1'b1, {(SAMPLE_W-1){1'b0}}};
    end else begin
      w_sat = w_acc_shift[SAMPLE_W-1:0];
    end
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_CLEAR;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, ring write port, coefficient address and accumulate enable
  always_comb begin
    w_state_nxt  = r_state;
    busy         = 1'b1;
    coef_rd_addr = '0;
    w_ring_we    = 1'b0;
    w_ring_waddr = r_wr_ptr;
    w_ring_wdata = sample_in;
    w_acc_en     = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_ring_we    = 1'b1;
        w_ring_waddr = r_clr_idx;
        w_ring_wdata = '0;
        if (r_clr_idx == {TAP_ADDR_W{1'b1}}) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_IDLE: begin
        busy = 1'b0;
        if (sample_strobe) begin
          w_ring_we   = 1'b1;
          w_state_nxt = ST_MAC;
        end
      end
      ST_MAC: begin
        coef_rd_addr = r_tap;
        // r_prod holds the previous tap's product from tap 1 onward.
        w_acc_en     = (r_tap != '0);
        if (r_tap == r_taps_n) begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        w_acc_en    = 1'b1;
        w_state_nxt = ST_OUT;
      end
      ST_OUT: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_CLEAR;
      end
    endcase
  end

  // Datapath
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_clr_idx    <= '0;
      r_wr_ptr     <= '0;
      r_tap        <= '0;
      r_taps_n     <= '0;
      r_prod       <= '0;
      r_acc        <= '0;
      r_filter_out <= '0;
      r_out_valid  <= 1'b0;
      r_overrun    <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      r_overrun   <= sample_strobe && (r_state != ST_IDLE);
      if (w_acc_en) begin
        r_acc <= r_acc + w_prod_ext;
      end
      case (r_state)
        ST_CLEAR: begin
          r_clr_idx <= r_clr_idx + 1'b1;
        end
        ST_IDLE: begin
          if (sample_strobe) begin
            r_taps_n <= taps_per_filter;
            r_acc    <= '0;
            r_tap    <= '0;
          end
        end
        ST_MAC: begin
          r_prod <= w_prod;
          r_tap  <= r_tap + 1'b1;
        end
        ST_OUT: begin
          r_filter_out <= w_sat;
          r_out_valid  <= 1'b1;
          r_wr_ptr     <= r_wr_ptr + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

  assign filter_out = r_filter_out;
  assign out_valid  = r_out_valid;
  assign overrun    = r_overrun;

endmodule : fir_coef_reader
`default_nettype wire

// File: tb/tb_fir_coef_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_fir_coef_reader                                            |
// | Purpose  : Self-checking bench for fir_coef_reader. A reference model    |
// |            keeps the accepted-sample history as a queue (newest first)   |
// |            and computes each output as a plain dot product, scaled and   |
// |            clamped. Honours FIR_ROUND_EN like the design.                |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_fir_coef_reader;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        sample_strobe;
  logic [23:0] sample_in;
  logic [7:0]  taps_per_filter;
  logic [7:0]  coef_rd_addr;
  logic [15:0] coefficients;
  logic [23:0] filter_out;
  logic        out_valid;
  logic        busy;
  logic        overrun;

  logic [15:0] coef_mem [256];
  logic [23:0] hist [$];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  assign coefficients = coef_mem[coef_rd_addr];

  fir_coef_reader #(
    .SAMPLE_W (24),
    .COEF_W   (16),
    .ACC_W    (48)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .sample_strobe   (sample_strobe),
    .sample_in       (sample_in),
    .taps_per_filter (taps_per_filter),
    .coef_rd_addr    (coef_rd_addr),
    .coefficients    (coefficients),
    .filter_out      (filter_out),
    .out_valid       (out_valid),
    .busy            (busy),
    .overrun         (overrun)
  );

  // ---------------- reference model ----------------
  function automatic logic [23:0] model_out(input int n);
    longint acc = 0;
    for (int k = 0; k <= n; k++) begin
      if (k < hist.size()) begin
        acc += longint'($signed(hist[k])) * longint'($signed(coef_mem[k]));
      end
    end
`ifdef FIR_ROUND_EN
    acc += 64'sd16384;
`endif
    acc = acc >>> 15;
    if (acc > 64'sd8388607)  return 24'h7FFFFF;
    if (acc < -64'sd8388608) return 24'h800000;
    return acc[23:0];
  endfunction

  function automatic void push_hist(input logic [23:0] s);
    hist.push_front(s);
    if (hist.size() > 256) void'(hist.pop_back());
  endfunction

  // Drive one accepted sample and observe until out_valid (bounded).
  // taps_per_filter and sample_in are scrambled right after the strobe.
  task automatic run_filter(input logic [23:0] s, input int n,
                            output int lat, output logic [23:0] y,
                            output int asum, output int ovr);
    lat = -1; y = '0; asum = 0; ovr = 0;
    @(negedge clk);
    sample_strobe   = 1'b1;
    sample_in       = s;
    taps_per_filter = 8'(n);
    @(posedge clk);
    push_hist(s);
    for (int e = 1; e <= 300 && lat < 0; e++) begin
      @(negedge clk);
      if (e == 1) begin
        sample_strobe   = 1'b0;
        taps_per_filter = 8'($urandom);
        sample_in       = 24'($urandom);
      end
      asum += int'(coef_rd_addr);
      @(posedge clk); #1;
      ovr += int'(overrun);
      if (out_valid) begin
        lat = e;
        y   = filter_out;
      end
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int cnt = 0;
    reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total += 5;
    if (busy !== 1'b1)            begin bad++; $display("FAIL reset_busy: got %b want 1", busy); end
    if (filter_out !== 24'h0)     begin bad++; $display("FAIL reset_filter_out: got %h want 000000", filter_out); end
    if (coef_rd_addr !== 8'h0)    begin bad++; $display("FAIL reset_coef_addr: got %h want 00", coef_rd_addr); end
    if (out_valid !== 1'b0)       begin bad++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    if (overrun !== 1'b0)         begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    @(negedge clk);
    reset_n = 1'b1;
    hist.delete();
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      cnt++;
      if (!busy) break;
    end
    total += 2;
    if (cnt !== 256) begin bad++; $display("FAIL clear_busy_cycles: got %0d want 256", cnt); end
    if (coef_rd_addr !== 8'h0) begin bad++; $display("FAIL idle_coef_addr: got %h want 00", coef_rd_addr); end
  endtask

  task automatic test_impulse();
    logic [23:0] smp [4];
    logic [23:0] exp_y [4];
    int lat, asum, ovr;
    logic [23:0] y;
    smp   = '{24'h100000, 24'h0, 24'h0, 24'h0};
    exp_y = '{24'h080000, 24'h040000, 24'h020000, 24'h010000};
    coef_mem[0] = 16'h4000; coef_mem[1] = 16'h2000;
    coef_mem[2] = 16'h1000; coef_mem[3] = 16'h0800;
    for (int i = 0; i < 4; i++) begin
      run_filter(smp[i], 3, lat, y, asum, ovr);
      total += 3;
      if (y !== exp_y[i]) begin bad++; $display("FAIL impulse_out[%0d]: got %h want %h", i, y, exp_y[i]); end
      if (lat !== 6)      begin bad++; $display("FAIL impulse_latency[%0d]: got %0d want 6", i, lat); end
      if (asum !== 6)     begin bad++; $display("FAIL impulse_addr_sum[%0d]: got %0d want 6", i, asum); end
    end
  endtask

  task automatic test_saturation();
    int lat, asum, ovr;
    logic [23:0] y, m;
    for (int k = 0; k < 4; k++) coef_mem[k] = 16'h7FFF;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < 4; i++) begin
        run_filter((p == 0) ? 24'h7FFFFF : 24'h800000, 3, lat, y, asum, ovr);
        m = model_out(3);
        total++;
        if (y !== m) begin bad++; $display("FAIL sat_model[%0d.%0d]: got %h want %h", p, i, y, m); end
      end
      total++;
      if (y !== ((p == 0) ? 24'h7FFFFF : 24'h800000)) begin
        bad++; $display("FAIL sat_final[%0d]: got %h want %h", p, y, (p == 0) ? 24'h7FFFFF : 24'h800000);
      end
    end
  endtask

  task automatic test_single_tap();
    int lat, asum, ovr;
    logic [23:0] y, want;
`ifdef FIR_ROUND_EN
    want = 24'h000002;
`else
    want = 24'h000001;
`endif
    coef_mem[0] = 16'h7FFF;
    run_filter(24'h000002, 0, lat, y, asum, ovr);
    total += 3;
    if (y !== want)  begin bad++; $display("FAIL single_tap_out: got %h want %h", y, want); end
    if (lat !== 3)   begin bad++; $display("FAIL single_tap_latency: got %0d want 3", lat); end
    if (asum !== 0)  begin bad++; $display("FAIL single_tap_addr_sum: got %0d want 0", asum); end
  endtask

  task automatic test_overrun();
    int ovr_cnt = 0, ov_cnt = 0, lat = -1, asum, ovr;
    logic [23:0] y = '0, m, s;
    for (int k = 0; k < 8; k++) coef_mem[k] = 16'($urandom);
    s = 24'($urandom);
    @(negedge clk);
    sample_strobe = 1'b1; sample_in = s; taps_per_filter = 8'd7;
    @(posedge clk);
    push_hist(s);
    m = model_out(7);
    for (int e = 1; e <= 40; e++) begin
      @(negedge clk);
      sample_strobe = (e == 3);
      sample_in     = 24'($urandom);
      @(posedge clk); #1;
      ovr_cnt += int'(overrun);
      if (out_valid) begin
        ov_cnt++;
        if (lat < 0) lat = e;
        y = filter_out;
      end
    end
    total += 4;
    if (ovr_cnt !== 1) begin bad++; $display("FAIL overrun_pulses: got %0d want 1", ovr_cnt); end
    if (ov_cnt !== 1)  begin bad++; $display("FAIL overrun_out_valids: got %0d want 1", ov_cnt); end
    if (lat !== 10)    begin bad++; $display("FAIL overrun_latency: got %0d want 10", lat); end
    if (y !== m)       begin bad++; $display("FAIL overrun_out: got %h want %h", y, m); end
    // The dropped sample must not appear in the history.
    run_filter(24'($urandom), 7, lat, y, asum, ovr);
    m = model_out(7);
    total++;
    if (y !== m) begin bad++; $display("FAIL overrun_history: got %h want %h", y, m); end
  endtask

  task automatic test_random();
    int lat, asum, ovr, n;
    logic [23:0] y, m;
    for (int k = 0; k < 256; k++) coef_mem[k] = 16'($urandom);
    for (int it = 0; it < 16; it++) begin
      n = int'($urandom_range(0, 20));
      run_filter(24'($urandom), n, lat, y, asum, ovr);
      m = model_out(n);
      total += 4;
      if (y !== m)                  begin bad++; $display("FAIL rand_out[%0d]: got %h want %h (n=%0d)", it, y, m, n); end
      if (lat !== n + 3)            begin bad++; $display("FAIL rand_latency[%0d]: got %0d want %0d", it, lat, n + 3); end
      if (asum !== n * (n + 1) / 2) begin bad++; $display("FAIL rand_addr_sum[%0d]: got %0d want %0d", it, asum, n * (n + 1) / 2); end
      if (ovr !== 0)                begin bad++; $display("FAIL rand_overrun[%0d]: got %0d want 0", it, ovr); end
    end
  endtask

  task automatic test_reset_mid();
    int ov_cnt = 0, low_busy = 0, cnt = 0, lat, asum, ovr;
    logic [23:0] y, m;
    @(negedge clk);
    sample_strobe = 1'b1; sample_in = 24'h123456; taps_per_filter = 8'd10;
    @(posedge clk);
    for (int e = 1; e <= 3; e++) begin
      @(negedge clk);
      sample_strobe = 1'b0;
      @(posedge clk); #1;
      ov_cnt += int'(out_valid);
    end
    @(negedge clk);
    reset_n = 1'b0;
    hist.delete();
    repeat (2) begin
      @(posedge clk); #1;
      ov_cnt += int'(out_valid);
      if (!busy) low_busy++;
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 400; c++) begin
      @(posedge clk); #1;
      cnt++;
      ov_cnt += int'(out_valid);
      if (!busy) break;
    end
    total += 3;
    if (ov_cnt !== 0)   begin bad++; $display("FAIL midreset_out_valid: got %0d want 0", ov_cnt); end
    if (low_busy !== 0) begin bad++; $display("FAIL midreset_busy_in_reset: got %0d low cycles want 0", low_busy); end
    if (cnt !== 256)    begin bad++; $display("FAIL midreset_clear_cycles: got %0d want 256", cnt); end
    run_filter(24'($urandom), 5, lat, y, asum, ovr);
    m = model_out(5);
    total++;
    if (y !== m) begin bad++; $display("FAIL midreset_after_out: got %h want %h", y, m); end
  endtask

  initial begin
    reset_n         = 1'b0;
    sample_strobe   = 1'b0;
    sample_in       = '0;
    taps_per_filter = '0;
    for (int k = 0; k < 256; k++) coef_mem[k] = '0;
    test_reset();
    test_impulse();
    test_saturation();
    test_single_tap();
    test_overrun();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fir_coef_reader
`default_nettype wire
